// File: rtl/gsn_div_seq_if.sv
// Valid/ready operand and result channels of the signed sequential divider.
interface gsn_div_seq_if #(
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 11
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_by_zero;
  logic                      overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/gsn_div_seq.sv
// Signed restoring divider, one quotient bit per cycle, for Gaussian filter
// normalisation (weighted sum / kernel weight sum).
//
// state | meaning
// IDLE  | ready for operands
// CALC  | restoring iterations, then one sign-fix/flag cycle
// DONE  | result valid, held until out_ready
module gsn_div_seq #(
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 11
) (
  input logic clk,
  input logic reset,
  gsn_div_seq_if.slave bus
);
  localparam int CW = $clog2(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIVIDEND_WIDTH - 1);
  localparam logic [DIVIDEND_WIDTH-1:0] Q_MAX = {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
  localparam logic [DIVIDEND_WIDTH-1:0] Q_MIN = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;

  logic [DIVIDEND_WIDTH-1:0] qm;
  logic [DIVISOR_WIDTH:0]    rem_p;
  logic [DIVISOR_WIDTH-1:0]  dvs_mag;
  logic [DIVISOR_WIDTH-1:0]  dvd_lo;
  logic                      neg_dvd, neg_dvs, zero_dvs, ovf, fix;
  logic [CW-1:0]             cnt;

  logic [DIVIDEND_WIDTH-1:0] q_r;
  logic [DIVISOR_WIDTH-1:0]  r_r;
  logic                      dbz_r, ovf_r;

  logic [DIVIDEND_WIDTH-1:0] dvd_abs;
  logic [DIVISOR_WIDTH-1:0]  dvs_abs;
  logic [DIVISOR_WIDTH:0]    sh, diff;
  logic                      ge;
  logic [DIVISOR_WIDTH-1:0]  rem_mag;

  // The most-negative operands negate onto themselves, which is the correct
  // unsigned magnitude.
  always_comb begin
    dvd_abs = bus.dividend[DIVIDEND_WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_abs = bus.divisor[DIVISOR_WIDTH-1]   ? -bus.divisor  : bus.divisor;
    sh      = {rem_p[DIVISOR_WIDTH-1:0], qm[DIVIDEND_WIDTH-1]};
    diff    = sh - {1'b0, dvs_mag};
    ge      = (sh >= {1'b0, dvs_mag});
    rem_mag = rem_p[DIVISOR_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      qm       <= '0;
      rem_p    <= '0;
      dvs_mag  <= '0;
      dvd_lo   <= '0;
      neg_dvd  <= 1'b0;
      neg_dvs  <= 1'b0;
      zero_dvs <= 1'b0;
      ovf      <= 1'b0;
      fix      <= 1'b0;
      cnt      <= '0;
      q_r      <= '0;
      r_r      <= '0;
      dbz_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            qm       <= dvd_abs;
            rem_p    <= '0;
            dvs_mag  <= dvs_abs;
            dvd_lo   <= bus.dividend[DIVISOR_WIDTH-1:0];
            neg_dvd  <= bus.dividend[DIVIDEND_WIDTH-1];
            neg_dvs  <= bus.divisor[DIVISOR_WIDTH-1];
            zero_dvs <= (bus.divisor == '0);
            ovf      <= (bus.dividend == Q_MIN) && (bus.divisor == '1);
            cnt      <= CNT_LOAD;
            fix      <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (!fix) begin
            qm    <= {qm[DIVIDEND_WIDTH-2:0], ge};
            rem_p <= ge ? diff : sh;
            if (cnt == '0) fix <= 1'b1;
            else           cnt <= cnt - CW'(1);
          end else begin
            // Iterations always run to completion; flags override the result here.
            if (zero_dvs) begin
              q_r <= neg_dvd ? Q_MIN : Q_MAX;
              r_r <= dvd_lo;
            end else if (ovf) begin
              q_r <= Q_MAX;
              r_r <= '0;
            end else begin
              q_r <= (neg_dvd ^ neg_dvs) ? -qm : qm;
              r_r <= neg_dvd ? -rem_mag : rem_mag;
            end
            dbz_r <= zero_dvs;
            ovf_r <= ovf & ~zero_dvs;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
endmodule
